// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and types for the 1x3 router
package router_pkg;

    localparam int NUM_PORTS       = 3;
    localparam int DEFAULT_TIMEOUT = 30;

    typedef logic [1:0] port_addr_t;

    localparam port_addr_t ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_timeout.sv
// rtl/router_timeout.sv - per-port stall counter issuing a one-cycle FIFO soft reset
module router_timeout #(
    parameter int TIMEOUT = 30,
    parameter int CNT_W   = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic vld,
    input  logic rd,
    output logic soft_reset
);

    logic [CNT_W-1:0] cnt;

    // Any read or an empty FIFO restarts the stall window from zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (!vld || rd) begin
            cnt        <= '0;
            soft_reset <= 1'b0;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            cnt        <= '0;
            soft_reset <= 1'b1;
        end else begin
            cnt        <= cnt + CNT_W'(1);
            soft_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/router_sync.sv
// rtl/router_sync.sv - address latch, write steering and output timeout control of the 1x3 router
module router_sync
    import router_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int CNT_W   = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       detect_add,
    input  logic [1:0] data_in,
    input  logic       write_enb_reg,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       empty_0,
    input  logic       empty_1,
    input  logic       empty_2,
    input  logic       full_0,
    input  logic       full_1,
    input  logic       full_2,
    output logic [2:0] write_enb,
    output logic       fifo_full,
    output logic       vld_out_0,
    output logic       vld_out_1,
    output logic       vld_out_2,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    port_addr_t addr_q;

    logic [NUM_PORTS-1:0] vld_vec;
    logic [NUM_PORTS-1:0] rd_vec;
    logic [NUM_PORTS-1:0] sr_vec;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= ADDR_INVALID;
        end else if (detect_add) begin
            addr_q <= data_in;
        end
    end

    // The invalid address steers nowhere and reports not-full.
    always_comb begin
        write_enb = 3'b000;
        fifo_full = 1'b0;
        case (addr_q)
            2'd0: begin
                write_enb = {2'b00, write_enb_reg};
                fifo_full = full_0;
            end
            2'd1: begin
                write_enb = {1'b0, write_enb_reg, 1'b0};
                fifo_full = full_1;
            end
            2'd2: begin
                write_enb = {write_enb_reg, 2'b00};
                fifo_full = full_2;
            end
            default: begin
                write_enb = 3'b000;
                fifo_full = 1'b0;
            end
        endcase
    end

    assign vld_out_0 = ~empty_0;
    assign vld_out_1 = ~empty_1;
    assign vld_out_2 = ~empty_2;

    assign vld_vec = {vld_out_2, vld_out_1, vld_out_0};
    assign rd_vec  = {read_enb_2, read_enb_1, read_enb_0};

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_timeout
        router_timeout #(
            .TIMEOUT(TIMEOUT),
            .CNT_W  (CNT_W)
        ) u_timeout (
            .clock     (clock),
            .reset     (reset),
            .vld       (vld_vec[i]),
            .rd        (rd_vec[i]),
            .soft_reset(sr_vec[i])
        );
    end

    assign soft_reset_0 = sr_vec[0];
    assign soft_reset_1 = sr_vec[1];
    assign soft_reset_2 = sr_vec[2];

endmodule

// File: tb/tb_router_sync.sv
// tb/tb_router_sync.sv - scoreboard bench for router_sync with directed vectors
module tb_router_sync;

    logic       clock;
    logic       reset;
    logic       detect_add;
    logic [1:0] data_in;
    logic       write_enb_reg;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       empty_0, empty_1, empty_2;
    logic       full_0, full_1, full_2;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    router_sync #(.TIMEOUT(30), .CNT_W(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .detect_add   (detect_add),
        .data_in      (data_in),
        .write_enb_reg(write_enb_reg),
        .read_enb_0   (read_enb_0),
        .read_enb_1   (read_enb_1),
        .read_enb_2   (read_enb_2),
        .empty_0      (empty_0),
        .empty_1      (empty_1),
        .empty_2      (empty_2),
        .full_0       (full_0),
        .full_1       (full_1),
        .full_2       (full_2),
        .write_enb    (write_enb),
        .fifo_full    (fifo_full),
        .vld_out_0    (vld_out_0),
        .vld_out_1    (vld_out_1),
        .vld_out_2    (vld_out_2),
        .soft_reset_0 (soft_reset_0),
        .soft_reset_1 (soft_reset_1),
        .soft_reset_2 (soft_reset_2)
    );

    typedef struct {
        logic [9:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, got timeout, required finish");
        $fatal(1);
    end

    // Monitor: every pushed cycle expectation is checked mid-cycle.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e   = sb.pop_front();
            act = {write_enb, fifo_full, vld_out_2, vld_out_1, vld_out_0,
                   soft_reset_2, soft_reset_1, soft_reset_0};
            compared++;
            if (act !== e.v) begin
                mismatched++;
                $display("FAIL %s @%0t: got we/ff/vld/sr=%b_%b_%b_%b required %b_%b_%b_%b",
                         e.name, $time, act[9:7], act[6], act[5:3], act[2:0],
                         e.v[9:7], e.v[6], e.v[5:3], e.v[2:0]);
            end
        end
    end

    task automatic cyc(input string name, input logic rst, input logic da,
                       input logic [1:0] din, input logic we, input logic [2:0] rd,
                       input logic [2:0] emp, input logic [2:0] full,
                       input logic [2:0] exp_we, input logic exp_ff, input logic [2:0] exp_sr);
        exp_t e;
        @(posedge clock);
        #1;
        reset         = rst;
        detect_add    = da;
        data_in       = din;
        write_enb_reg = we;
        {read_enb_2, read_enb_1, read_enb_0} = rd;
        {empty_2, empty_1, empty_0}          = emp;
        {full_2, full_1, full_0}             = full;
        e.v    = {exp_we, exp_ff, ~emp, exp_sr};
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic idle();
        cyc("idle", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000);
    endtask

    initial begin
        reset = 1'b1; detect_add = 1'b0; data_in = 2'd0; write_enb_reg = 1'b0;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        empty_0 = 1'b1; empty_1 = 1'b1; empty_2 = 1'b1;
        full_0 = 1'b0; full_1 = 1'b0; full_2 = 1'b0;

        cyc("reset_state", 1'b1, 1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000);
        cyc("reset_state", 1'b1, 1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000);

        // Address decode and full mux
        cyc("hdr_port1",      1'b0, 1'b1, 2'd1, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++)
            cyc("wr_port1",   1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b000, 3'b010, 1'b0, 3'b000);
        cyc("full1_tracked",  1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b010, 3'b010, 1'b1, 3'b000);
        cyc("full_others",    1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b101, 3'b010, 1'b0, 3'b000);
        cyc("hdr_same_cycle", 1'b0, 1'b1, 2'd2, 1'b1, 3'b000, 3'b111, 3'b000, 3'b010, 1'b0, 3'b000);
        cyc("wr_port2",       1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b100, 3'b100, 1'b1, 3'b000);
        cyc("hdr_port0",      1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000);
        cyc("wr_port0",       1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b001, 3'b001, 1'b1, 3'b000);
        cyc("hdr_inv_old",    1'b0, 1'b1, 2'd3, 1'b1, 3'b000, 3'b111, 3'b111, 3'b001, 1'b1, 3'b000);
        cyc("wr_invalid",     1'b0, 1'b0, 2'd0, 1'b1, 3'b000, 3'b111, 3'b111, 3'b000, 1'b0, 3'b000);
        cyc("hdr_port0_b",    1'b0, 1'b1, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000);
        cyc("no_wr_req",      1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 3'b000);
        idle();

        // Port 2 stall: pulse in cycles 30 and 60, other ports quiet
        for (int j = 0; j < 62; j++)
            cyc("stall_port2", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0,
                (j == 30 || j == 60) ? 3'b100 : 3'b000);
        idle();

        // Port 0 stall with a read in cycle 20: pulse moves to cycle 51
        for (int j = 0; j < 56; j++)
            cyc("read_restart", 1'b0, 1'b0, 2'd0, 1'b0, (j == 20) ? 3'b001 : 3'b000, 3'b110,
                3'b000, 3'b000, 1'b0, (j == 51) ? 3'b001 : 3'b000);
        idle();

        // All ports stall together
        for (int j = 0; j < 32; j++)
            cyc("stall_all", 1'b0, 1'b0, 2'd0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0,
                (j == 30) ? 3'b111 : 3'b000);
        idle();

        // Reset during cycle 15 of a port 0 stall; addr 0 is lost immediately
        for (int j = 0; j < 51; j++)
            cyc((j < 15) ? "pre_reset_wr" : "post_reset", (j == 15), 1'b0, 2'd0, 1'b1, 3'b000,
                3'b110, 3'b000, (j < 15) ? 3'b001 : 3'b000, 1'b0,
                (j == 46) ? 3'b001 : 3'b000);

        @(negedge clock);
        #1;
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
